// File: rtl/skid_reg.sv
// Two-slot registered valid/ready stage: main slot drives the output, skid slot
// absorbs the one beat that arrives while downstream stalls. All outputs are flops.
module skid_reg #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_vld,
    output logic                  din_rd,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_vld,
    input  logic                  dout_rd
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Declaration values make power-up match the reset state.
    logic [1:0]            state_q    = ST_EMPTY;
    logic [DATA_WIDTH-1:0] main_q     = '0;
    logic [DATA_WIDTH-1:0] skid_q     = '0;
    logic                  din_rd_q   = 1'b1;
    logic                  dout_vld_q = 1'b0;

    logic [1:0]            state_d;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] skid_d;
    logic                  in_xfer;
    logic                  out_xfer;

    assign in_xfer  = din_vld & din_rd_q;
    assign out_xfer = dout_vld_q & dout_rd;

    // Next state and slot contents.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_d  = din_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = din_data;
                end else if (in_xfer) begin
                    skid_d  = din_data;
                    state_d = ST_FULL;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Handshake flags are precomputed from the next state so they stay pure flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            din_rd_q   <= 1'b1;
            dout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            din_rd_q   <= (state_d != ST_FULL);
            dout_vld_q <= (state_d != ST_EMPTY);
        end
    end

    assign din_rd    = din_rd_q;
    assign dout_vld  = dout_vld_q;
    assign dout_data = main_q;

endmodule

// File: tb/tb_skid_reg.sv
// Bench for skid_reg: directed scenarios plus a random run, with an occupancy
// model and an expected-payload queue checked by a negedge monitor.
module tb_skid_reg;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din_data;
    logic          din_vld;
    logic          din_rd;
    logic [DW-1:0] dout_data;
    logic          dout_vld;
    logic          dout_rd;

    int            errors = 0;
    int            checks = 0;
    int            n_out  = 0;
    int            n_in   = 0;
    int            occ    = 0;
    logic [DW-1:0] exp_q[$];

    skid_reg #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .din_data  (din_data),
        .din_vld   (din_vld),
        .din_rd    (din_rd),
        .dout_data (dout_data),
        .dout_vld  (dout_vld),
        .dout_rd   (dout_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: occupancy model predicts handshakes; queue head predicts dout_data.
    always @(negedge clk) begin
        logic in_x;
        logic out_x;
        if (rst) begin
            exp_q.delete();
            occ = 0;
        end else begin
            chk("din_rd_vs_model", 32'(din_rd), 32'(occ != 2));
            chk("dout_vld_vs_model", 32'(dout_vld), 32'(occ != 0));
            if (dout_vld) begin
                if (exp_q.size() == 0) chk("dout_unexpected", 32'(dout_data), 32'hFFFF_FFFF);
                else chk("dout_data_order", 32'(dout_data), 32'(exp_q[0]));
            end
            in_x  = din_vld && (occ != 2);
            out_x = dout_rd && (occ != 0);
            if (in_x) begin
                exp_q.push_back(din_data);
                n_in++;
            end
            if (out_x && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                n_out++;
            end
            occ = occ + int'(in_x) - int'(out_x);
        end
    end

    initial begin
        int base;
        int idx;
        int budget;
        bit ok;
        logic [DW-1:0] pay[1000];

        rst = 1'b1; din_vld = 1'b0; din_data = '0; dout_rd = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("reset_dout_vld", 32'(dout_vld), 32'd0);
        chk("reset_din_rd", 32'(din_rd), 32'd1);
        chk("reset_dout_data", 32'(dout_data), 32'd0);
        step();

        // Streaming 0x01..0x10 at full rate.
        base = n_out;
        dout_rd = 1'b1; din_vld = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            din_data = DW'(i);
            step();
            chk("stream_latency_vld", 32'(dout_vld), 32'd1);
            chk("stream_latency_data", 32'(dout_data), 32'(i));
            chk("stream_din_rd", 32'(din_rd), 32'd1);
        end
        din_vld = 1'b0;
        step(); step();
        chk("stream_out_count", 32'(n_out - base), 32'd16);

        // Backpressure: A1, A2 accepted, A3 held upstream.
        dout_rd = 1'b0; din_vld = 1'b1;
        din_data = 8'hA1; step();
        din_data = 8'hA2; step();
        chk("bp_din_rd_low", 32'(din_rd), 32'd0);
        din_data = 8'hA3; step(); step(); step();
        chk("bp_head_held", 32'(dout_data), 32'hA1);
        chk("bp_still_full", 32'(din_rd), 32'd0);
        dout_rd = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (din_rd) begin
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        din_vld = 1'b0;
        chk("bp_a3_accepted", 32'(ok), 32'd1);
        step(); step(); step(); step();

        // Stall stability with toggling din_data.
        dout_rd = 1'b0; din_vld = 1'b1; din_data = 8'h5C; step();
        din_vld = 1'b0;
        for (int k = 0; k < 10; k++) begin
            din_data = (k % 2 == 0) ? 8'hFF : 8'h00;
            step();
            chk("stall_stable", 32'(dout_data), 32'h5C);
        end
        dout_rd = 1'b1; step(); step();

        // Drain from FULL.
        dout_rd = 1'b0; din_vld = 1'b1;
        din_data = 8'h11; step();
        din_data = 8'h22; step();
        din_vld = 1'b0;
        chk("drain_full_din_rd", 32'(din_rd), 32'd0);
        chk("drain_head", 32'(dout_data), 32'h11);
        dout_rd = 1'b1; step();
        chk("drain_second", 32'(dout_data), 32'h22);
        chk("drain_second_vld", 32'(dout_vld), 32'd1);
        step();
        chk("drain_empty_vld", 32'(dout_vld), 32'd0);
        chk("drain_empty_rd", 32'(din_rd), 32'd1);

        // Reset while FULL, with a transfer attempted during reset.
        dout_rd = 1'b0; din_vld = 1'b1;
        din_data = 8'h33; step();
        din_data = 8'h44; step();
        rst = 1'b1; dout_rd = 1'b1; din_data = 8'h55; step();
        rst = 1'b0; din_vld = 1'b0;
        chk("rst_mid_dout_vld", 32'(dout_vld), 32'd0);
        chk("rst_mid_din_rd", 32'(din_rd), 32'd1);
        chk("rst_mid_dout_data", 32'(dout_data), 32'd0);
        base = n_out;
        step(); step(); step();
        chk("rst_mid_no_output", 32'(n_out - base), 32'd0);

        // Random handshakes over 1000 payloads.
        for (int i = 0; i < 1000; i++) pay[i] = DW'($urandom);
        base = n_out;
        idx = 0;
        budget = 20000;
        while (idx < 1000 && budget > 0) begin
            din_vld  = 1'($urandom_range(0, 1));
            dout_rd  = 1'($urandom_range(0, 1));
            din_data = din_vld ? pay[idx] : DW'($urandom);
            ok = din_vld && din_rd;
            step();
            if (ok) idx++;
            budget--;
        end
        chk("rand_all_sent", 32'(idx), 32'd1000);
        din_vld = 1'b0; dout_rd = 1'b1;
        budget = 20;
        while (dout_vld && budget > 0) begin
            step();
            budget--;
        end
        chk("rand_drained", 32'(dout_vld), 32'd0);
        chk("rand_out_count", 32'(n_out - base), 32'd1000);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/skid_reg.md
SKID_REG -- requirements
Module: skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, defining the payload width in bits.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 The block SHALL have port rst, input, 1, synchronous, active-high reset; the clock is clk.
REQ-004 The block SHALL have port din_data, input, DATA_WIDTH, upstream payload.
REQ-005 The block SHALL have port din_vld, input, 1, upstream payload valid.
REQ-006 The block SHALL have port din_rd, output, 1, block ready to accept upstream payload.
REQ-007 The block SHALL have port dout_data, output, DATA_WIDTH, downstream payload.
REQ-008 The block SHALL have port dout_vld, output, 1, downstream payload valid.
REQ-009 The block SHALL have port dout_rd, input, 1, downstream ready.

Function
REQ-010 The block SHALL be a registered valid/ready pipeline stage with two storage slots: main slot (drives dout_*) and skid slot.
REQ-011 An input transfer SHALL occur on a clk edge with din_vld=1 and din_rd=1; an output transfer SHALL occur on a clk edge with dout_vld=1 and dout_rd=1.
REQ-012 The block SHALL hold state EMPTY (no slot valid), ONE (main valid only) or FULL (main and skid valid).
REQ-013 din_rd SHALL be driven directly from a flop and SHALL be 1 exactly when state is not FULL; it SHALL NOT depend combinationally on dout_rd.
REQ-014 dout_vld SHALL be 1 exactly in ONE or FULL; dout_data SHALL equal the main slot and SHALL depend on no input combinationally.
REQ-015 EMPTY: input transfer -> payload to main, next ONE; otherwise stay EMPTY.
REQ-016 ONE: input and output transfer together -> new payload to main, stay ONE; input only -> payload to skid, next FULL; output only -> next EMPTY; neither -> hold.
REQ-017 FULL: output transfer -> skid moves to main, next ONE; otherwise hold all data; no input transfer is possible.
REQ-018 Latency SHALL be exactly 1 cycle: payload accepted at edge N SHALL appear on dout_data with dout_vld=1 after edge N when no older payload is pending.
REQ-019 Sustained throughput SHALL be one transfer per cycle when din_vld=1 and dout_rd=1 continuously.
REQ-020 Payload order SHALL be preserved; no payload SHALL be dropped, duplicated or modified.
REQ-021 While dout_vld=1 and dout_rd=0, dout_data SHALL remain stable.
REQ-022 din_data SHALL be ignored when din_vld=0 or din_rd=0.

Reset
REQ-023 On a clk edge with rst=1 the block SHALL enter EMPTY regardless of all other inputs, including a transfer in progress.
REQ-024 After reset: dout_vld=0, din_rd=1, dout_data=0 and skid slot=0.
REQ-025 Payloads held at reset assertion SHALL be discarded and SHALL NOT appear at dout after rst deasserts.
REQ-026 Power-up (initial) values SHALL equal the reset values.

Verification
REQ-027 Streaming: dout_rd=1, din_vld=1, din_data 0x01..0x10 on consecutive cycles -> dout_data 0x01..0x10 one cycle later, dout_vld=1 for 16 consecutive cycles, din_rd stays 1.
REQ-028 Backpressure: send 0xA1, 0xA2, 0xA3 with dout_rd=0 -> 0xA1 and 0xA2 accepted, din_rd=0 after second accept, 0xA3 held upstream; raise dout_rd -> output 0xA1, 0xA2, 0xA3 in order.
REQ-029 Stall stability: dout_vld=1 with 0x5C, dout_rd=0 for 10 cycles while din_data toggles -> dout_data stays 0x5C.
REQ-030 Drain from FULL: FULL holding 0x11, 0x22; din_vld=0, dout_rd=1 -> 0x11 then 0x22, then dout_vld=0, din_rd=1.
REQ-031 Reset mid-operation: FULL with 0x33, 0x44, assert rst one cycle -> next cycle dout_vld=0, din_rd=1, dout_data=0; 0x33 and 0x44 never appear.
REQ-032 Random: random din_vld and dout_rd (50%) with 1000 random payloads -> output sequence equals input sequence, no data change during stall, din_rd never 1 in FULL.
